// File: rtl/tx_bit_feeder_pkg.sv
// tx_bit_feeder shared parameters and types.
// Encoder limits, code-rate codes and the feeder FSM state set.
package tx_bit_feeder_pkg;

    localparam int MAX_CONSTRAINT_LENGTH = 7;
    localparam int MAX_CODE_RATE = 3;
    localparam int POLY_W = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;

    localparam int FRAME_LEN_DEF = 128;

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_WAIT,
        ST_DONE
    } fsm_state_t;

endpackage

// File: rtl/tx_bit_feeder_if.sv
// tx_bit_feeder upstream frame handshake bundle.
// master offers a frame, slave (the feeder) accepts it with frame_ready.
interface tx_bit_feeder_if
    import tx_bit_feeder_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
);
    logic                 frame_valid;
    logic                 frame_ready;
    logic [FRAME_LEN-1:0] frame_data;
    logic                 code_rate;
    logic [POLY_W-1:0]    gen_poly;

    modport master (
        output frame_valid,
        output frame_data,
        output code_rate,
        output gen_poly,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_data,
        input  code_rate,
        input  gen_poly,
        output frame_ready
    );
endinterface

// File: rtl/tx_bit_feeder_piso_shifter.sv
// tx_bit_feeder parallel-in serial-out shifter with bit counter.
// Presents the frame MSB first; the counter tracks bits handed off.
module piso_shifter #(
    parameter int WIDTH = 128,
    parameter int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             cnt_inc,
    input  logic             cnt_clr,
    output logic             msb,
    output logic [CW-1:0]    cnt
);
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // next shift-register contents and bit count
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else begin
            if (shift) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (cnt_inc) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // shifter and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb = sr_q[WIDTH-1];
    assign cnt = cnt_q;
endmodule

// File: rtl/tx_bit_feeder.sv
// tx_bit_feeder: serialises a latched frame into a convolutional encoder.
// Restarts the encoder, feeds FRAME_LEN bits MSB first, waits for done.
module tx_bit_feeder
    import tx_bit_feeder_pkg::*;
#(
    parameter int FRAME_LEN    = FRAME_LEN_DEF,
    parameter int DONE_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_frame_valid,
    output logic                 o_frame_ready,
    input  logic [FRAME_LEN-1:0] i_frame_data,
    input  logic                 i_code_rate,
    input  logic [POLY_W-1:0]    i_gen_poly,
    output logic                 o_enc_rst,
    output logic                 o_en_ce,
    output logic                 o_tx_data,
    output logic                 o_code_rate,
    output logic [POLY_W-1:0]    o_gen_poly,
    input  logic                 i_encoder_done,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_error
);
    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    fsm_state_t state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic ready_q, ready_d;
    logic enc_rst_q, enc_rst_d;
    logic en_ce_q, en_ce_d;
    logic tx_q, tx_d;
    logic rate_q, rate_d;
    logic [POLY_W-1:0] poly_q, poly_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic          load;
    logic          shift;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          msb;
    logic [CW-1:0] bit_cnt;

    piso_shifter #(
        .WIDTH(FRAME_LEN),
        .CW   (CW)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst),
        .load     (load),
        .load_data(i_frame_data),
        .shift    (shift),
        .cnt_inc  (cnt_inc),
        .cnt_clr  (cnt_clr),
        .msb      (msb),
        .cnt      (bit_cnt)
    );

    // next state, shifter control and registered-output values
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        rate_d   = rate_q;
        poly_d   = poly_q;
        load     = 1'b0;
        shift    = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_frame_valid && ready_q) begin
                    load    = 1'b1;
                    rate_d  = i_code_rate;
                    poly_d  = i_gen_poly;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                shift   = 1'b1;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (bit_cnt == CW'(FRAME_LEN - 1)) begin
                    cnt_clr  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                end else begin
                    shift   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (i_encoder_done) begin
                    to_cnt_d = '0;
                    state_d  = ST_DONE;
                end else if (to_cnt_d == TW'(DONE_TIMEOUT)) begin
                    to_cnt_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = (state_d == ST_IDLE);
        enc_rst_d = (state_d != ST_CLR);
        en_ce_d   = (state_d == ST_FEED);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        tx_d      = shift ? msb : 1'b0;
    end

    // state, timeout counter and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            ready_q   <= 1'b0;
            enc_rst_q <= 1'b0;
            en_ce_q   <= 1'b0;
            tx_q      <= 1'b0;
            rate_q    <= 1'b0;
            poly_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            ready_q   <= ready_d;
            enc_rst_q <= enc_rst_d;
            en_ce_q   <= en_ce_d;
            tx_q      <= tx_d;
            rate_q    <= rate_d;
            poly_q    <= poly_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_frame_ready = ready_q;
    assign o_enc_rst     = enc_rst_q;
    assign o_en_ce       = en_ce_q;
    assign o_tx_data     = tx_q;
    assign o_code_rate   = rate_q;
    assign o_gen_poly    = poly_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_error       = err_q;
endmodule

// File: tb/tb_tx_bit_feeder.sv
// tx_bit_feeder bench: random frames against a frame-timeline model.
// Directed phases pin the timing the model relies on.
module tb_tx_bit_feeder;
    import tx_bit_feeder_pkg::*;

    localparam int L  = 128;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic o_enc_rst, o_en_ce, o_tx_data, o_code_rate;
    logic [POLY_W-1:0] o_gen_poly;
    logic i_encoder_done;
    logic o_busy, o_frame_done, o_error;

    tx_bit_feeder_if #(.FRAME_LEN(L)) up ();

    tx_bit_feeder #(
        .FRAME_LEN   (L),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (up.frame_valid),
        .o_frame_ready (up.frame_ready),
        .i_frame_data  (up.frame_data),
        .i_code_rate   (up.code_rate),
        .i_gen_poly    (up.gen_poly),
        .o_enc_rst     (o_enc_rst),
        .o_en_ce       (o_en_ce),
        .o_tx_data     (o_tx_data),
        .o_code_rate   (o_code_rate),
        .o_gen_poly    (o_gen_poly),
        .i_encoder_done(i_encoder_done),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // frame-timeline model: t = cycles since acceptance, -1 when idle
    int t = -1;
    bit in_rst = 1'b1;
    bit err_now = 1'b0;
    logic [L-1:0] m_data = '0;
    logic m_rate = 1'b0;
    logic [POLY_W-1:0] m_poly = '0;
    int plan = 0;

    // stimulus control
    bit dir_mode = 1'b1;
    bit dir_valid = 1'b0;
    bit dir_once = 1'b0;
    int dir_plan = -1;
    logic [L-1:0] dir_data = '0;
    logic dir_rate = 1'b0;
    logic [POLY_W-1:0] dir_poly = '0;

    // observations of the DUT for literal checks
    int ce_cnt, ones, first_k, last_k, clr_cnt;
    int done_cnt, err_cnt, err_cyc, last_ce;
    int done_cyc0, done_cyc1;
    logic done_rate;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic bound_chk(input string nm, input int g, input int lim);
        checks++;
        if (g >= lim) begin
            errors++;
            $display("FAIL %s: waited %0d cycles, limit %0d", nm, g, lim);
        end
    endtask

    task automatic clear_obs();
        ce_cnt = 0; ones = 0; first_k = -1; last_k = -1; clr_cnt = 0;
        done_cnt = 0; err_cnt = 0; err_cyc = 0; last_ce = 0;
        done_cyc0 = 0; done_cyc1 = 0; done_rate = 1'b0;
    endtask

    function automatic logic [7:0] expect_ctrl();
        logic r, e, c, x, b, d;
        int w;
        r = 1'b0; e = 1'b0; c = 1'b0; x = 1'b0; b = 1'b0; d = 1'b0;
        if (in_rst) return 8'h00;
        if (t < 0) begin
            r = 1'b1; e = 1'b1;
        end else if (t == 1) begin
            b = 1'b1;
        end else if (t <= L + 1) begin
            e = 1'b1; c = 1'b1; b = 1'b1;
            x = m_data[L - 1 - (t - 2)];
        end else begin
            w = t - (L + 2);
            e = 1'b1; b = 1'b1;
            d = (plan < TO) && (w == plan + 1);
        end
        return {r, e, c, x, m_rate, b, d, err_now};
    endfunction

    function automatic logic [7:0] actual_ctrl();
        return {up.frame_ready, o_enc_rst, o_en_ce, o_tx_data,
                o_code_rate, o_busy, o_frame_done, o_error};
    endfunction

    task automatic observe();
        if (o_en_ce) begin
            if (o_tx_data) begin
                if (ones == 0) first_k = ce_cnt;
                last_k = ce_cnt;
                ones++;
            end
            ce_cnt++;
            last_ce = cyc;
        end
        if (!o_enc_rst && rst) clr_cnt++;
        if (o_frame_done) begin
            done_cyc0 = done_cyc1;
            done_cyc1 = cyc;
            done_rate = o_code_rate;
            done_cnt++;
        end
        if (o_error) begin
            err_cyc = cyc;
            err_cnt++;
        end
    endtask

    task automatic drive_inputs();
        int w;
        int lastw;
        if (dir_mode) begin
            up.frame_valid = dir_valid;
            up.frame_data  = dir_data;
            up.code_rate   = dir_rate;
            up.gen_poly    = dir_poly;
        end else begin
            up.frame_valid = ($urandom_range(0, 3) != 0);
            up.frame_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            up.code_rate   = 1'($urandom());
            up.gen_poly    = POLY_W'($urandom());
        end
        w = t - (L + 2);
        lastw = (plan < TO) ? plan : TO - 1;
        if (!in_rst && t >= L + 2 && w <= lastw)
            i_encoder_done = (w >= plan);
        else
            i_encoder_done = 1'($urandom());
    endtask

    task automatic model_step(input bit cur_ready);
        err_now = 1'b0;
        if (in_rst) return;
        if (t < 0) begin
            if (cur_ready && up.frame_valid) begin
                t = 1;
                m_data = up.frame_data;
                m_rate = up.code_rate;
                m_poly = up.gen_poly;
                plan = (dir_plan >= 0) ? dir_plan : $urandom_range(0, TO + 1);
                if (dir_once) dir_valid = 1'b0;
            end
        end else begin
            t++;
            if (plan < TO && t - (L + 2) == plan + 2) begin
                t = -1;
            end else if (plan >= TO && t - (L + 2) == TO) begin
                t = -1;
                err_now = 1'b1;
            end
        end
    endtask

    // one clock: compare outputs, then drive and advance the model
    task automatic step(input int rst_act);
        logic [7:0] ev;
        bit cur_ready;
        @(negedge clk);
        cyc++;
        ev = expect_ctrl();
        chk("ctrl", 32'(actual_ctrl()), 32'(ev));
        chk("poly", 32'(o_gen_poly), in_rst ? 32'h0 : 32'(m_poly));
        observe();
        cur_ready = ev[7];
        if (rst_act == 1) begin
            rst = 1'b0;
            in_rst = 1'b1;
            t = -1;
            m_rate = 1'b0;
            m_poly = '0;
            #1;
            chk("async_rst_ctrl", 32'(actual_ctrl()), 32'h0);
            chk("async_rst_poly", 32'(o_gen_poly), 32'h0);
        end else if (rst_act == 2) begin
            rst = 1'b1;
            in_rst = 1'b0;
        end
        drive_inputs();
        model_step(cur_ready);
    endtask

    initial begin
        int g;
        rst = 1'b1;
        up.frame_valid = 1'b0;
        up.frame_data = '0;
        up.code_rate = 1'b0;
        up.gen_poly = '0;
        i_encoder_done = 1'b0;
        clear_obs();
        #1 rst = 1'b0;
        #1;
        chk("reset_ctrl", 32'(actual_ctrl()), 32'h0);
        chk("reset_poly", 32'(o_gen_poly), 32'h0);
        step(0);
        step(0);
        step(2);
        step(0);
        chk("post_rst_ready", 32'(up.frame_ready), 32'h1);
        chk("post_rst_enc_rst", 32'(o_enc_rst), 32'h1);

        // MSB and LSB set: only first and last fed bits are ones
        clear_obs();
        dir_data = '0;
        dir_data[L-1] = 1'b1;
        dir_data[0] = 1'b1;
        dir_rate = CODE_RATE_2;
        dir_poly = POLY_W'(21'h3D);
        dir_plan = 0;
        dir_once = 1'b1;
        dir_valid = 1'b1;
        g = 0;
        while (done_cnt < 1 && g < 400) begin step(0); g++; end
        bound_chk("bound_edge_frame", g, 400);
        for (int i = 0; i < 3; i++) step(0);
        chk("edge_ce_cycles", 32'(ce_cnt), 32'd128);
        chk("edge_ones", 32'(ones), 32'd2);
        chk("edge_first_k", 32'(first_k), 32'd0);
        chk("edge_last_k", 32'(last_k), 32'd127);
        chk("edge_clr_cycles", 32'(clr_cnt), 32'd1);

        // valid held high across two frames
        clear_obs();
        dir_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        dir_once = 1'b0;
        dir_valid = 1'b1;
        g = 0;
        while (done_cnt < 2 && g < 600) begin step(0); g++; end
        bound_chk("bound_back_to_back", g, 600);
        dir_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(0);
        chk("b2b_done_pulses", 32'(done_cnt), 32'd2);
        chk("b2b_gap", 32'(done_cyc1 - done_cyc0), 32'd132);

        // encoder never reports done
        clear_obs();
        dir_plan = TO + 1;
        dir_once = 1'b1;
        dir_valid = 1'b1;
        g = 0;
        while (err_cnt < 1 && g < 400) begin step(0); g++; end
        bound_chk("bound_timeout", g, 400);
        step(0);
        chk("timeout_ready_after", 32'(up.frame_ready), 32'h1);
        chk("timeout_delay", 32'(err_cyc - last_ce), 32'd5);
        chk("timeout_no_done", 32'(done_cnt), 32'd0);

        // reset at FEED bit 60, then a rate-3 frame
        clear_obs();
        dir_plan = 0;
        dir_rate = CODE_RATE_2;
        dir_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        dir_once = 1'b1;
        dir_valid = 1'b1;
        g = 0;
        while (t != 61 && g < 400) begin step(0); g++; end
        bound_chk("bound_feed60", g, 400);
        step(1);
        step(0);
        dir_rate = CODE_RATE_3;
        dir_poly = POLY_W'(21'h1F_ADB);
        dir_plan = 2;
        dir_valid = 1'b1;
        step(2);
        g = 0;
        while (done_cnt < 1 && g < 400) begin step(0); g++; end
        bound_chk("bound_rate3", g, 400);
        chk("rate3_done_rate", 32'(done_rate), 32'h1);
        chk("abort_no_error", 32'(err_cnt), 32'd0);

        // randomised frames with varying inputs mid-frame
        clear_obs();
        dir_mode = 1'b0;
        dir_once = 1'b0;
        dir_plan = -1;
        g = 0;
        while (done_cnt + err_cnt < 30 && g < 8000) begin step(0); g++; end
        bound_chk("bound_random", g, 8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_bit_feeder.md
TX_BIT_FEEDER -- requirements
Module: tx_bit_feeder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 128, payload bits per frame (matches the encoder's 128-step frame).
REQ-002 SHALL have parameter DONE_TIMEOUT, default 4, maximum cycles to wait for encoder done after the last bit.
REQ-003 Clock is clk, reset is rst; one clock domain; rst is asynchronous and active-low.
REQ-004 Ports, in order:
- clk  in  1  clock
- rst  in  1  async active-low reset
- i_frame_valid  in  1  upstream frame offered
- o_frame_ready  out  1  feeder accepts a frame this cycle
- i_frame_data  in  FRAME_LEN  payload; bit FRAME_LEN-1 is transmitted first
- i_code_rate  in  1  CODE_RATE_2 or CODE_RATE_3, sampled with the frame
- i_gen_poly  in  MAX_CONSTRAINT_LENGTH x MAX_CODE_RATE  generator polynomials, sampled with the frame
- o_enc_rst  out  1  active-low restart to the encoder
- o_en_ce  out  1  encoder clock enable
- o_tx_data  out  1  serial bit to the encoder
- o_code_rate  out  1  latched rate to the encoder
- o_gen_poly  out  MAX_CONSTRAINT_LENGTH x MAX_CODE_RATE  latched polynomials to the encoder
- i_encoder_done  in  1  encoder frame-complete flag
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse, frame encoded
- o_error  out  1  one-cycle pulse, done timeout

Function
REQ-005 SHALL implement FSM states IDLE, CLR, FEED, WAIT, DONE; all outputs registered.
REQ-006 IDLE: o_frame_ready=1; on i_frame_valid&&o_frame_ready, latch data, rate and poly, then go to CLR.
REQ-007 o_frame_ready SHALL be 0 in every state except IDLE; a frame offered while busy stays pending, with no drop and no overwrite.
REQ-008 CLR: o_enc_rst=0 for exactly one cycle, o_en_ce=0, then go to FEED.
REQ-009 FEED: o_en_ce=1 for exactly FRAME_LEN consecutive cycles.
REQ-010 In FEED cycle k (0-based), o_tx_data SHALL equal latched bit FRAME_LEN-1-k (MSB first), using a shift register plus a bit counter.
REQ-011 The bit counter SHALL be $clog2(FRAME_LEN)+1 bits wide and leave FEED when it reaches FRAME_LEN-1; no wrap-around.
REQ-012 WAIT: o_en_ce=0 and o_tx_data=0.
REQ-013 WAIT exit on i_encoder_done=1: go to DONE.
REQ-014 WAIT exit when the timeout counter reaches DONE_TIMEOUT with no done: pulse o_error and go to IDLE without a done pulse.
REQ-015 i_encoder_done already high on WAIT entry SHALL count as done on the first WAIT cycle.
REQ-016 DONE: o_frame_done=1 for one cycle, then go to IDLE; earliest next acceptance is the cycle after DONE.
REQ-017 o_busy SHALL be 1 in CLR, FEED, WAIT and DONE, and 0 in IDLE.
REQ-018 o_code_rate and o_gen_poly SHALL hold the latched values from acceptance until the next acceptance, stable through the whole frame.
REQ-019 i_encoder_done seen outside WAIT SHALL be ignored.

Reset
REQ-020 While rst=0, regardless of clock, SHALL force:
- state IDLE, counters 0
- o_frame_ready=0, o_enc_rst=0, o_en_ce=0, o_tx_data=0
- o_code_rate=0, o_gen_poly all 0
- o_busy=0, o_frame_done=0, o_error=0
REQ-021 First cycle after rst deasserts: o_frame_ready=1, o_enc_rst=1.
REQ-022 Reset during FEED or WAIT SHALL abort the frame with no done or error pulse; the aborted frame is not replayed.

Structure
REQ-023 The FSM state enum and the FRAME_LEN default SHALL live in the shared parameter package, beside MAX_CONSTRAINT_LENGTH and MAX_CODE_RATE.
REQ-024 The block SHALL use the existing CODE_RATE_2/CODE_RATE_3 definitions and redefine nothing.
REQ-025 The block SHALL be one module; the shift register plus bit counter MAY be a sub-module named piso_shifter.

Verification
REQ-026 Accept 128'h8000...0001 at rate 2 -> CLR for 1 cycle, then 128 en_ce cycles; o_tx_data=1 at k=0 and k=127, 0 elsewhere.
REQ-027 Feeder plus encoder, rate 2, poly {7,5}, data all-ones -> o_frame_done one cycle after i_encoder_done; encoder output matches the golden model.
REQ-028 i_frame_valid held high across two frames -> second handshake only after DONE; exactly 2 o_frame_done pulses, gap >= 131 cycles.
REQ-029 Tie i_encoder_done=0 -> o_error pulse 4 cycles after WAIT entry, o_frame_done never asserts, next cycle o_frame_ready=1.
REQ-030 Assert rst low at FEED bit 60 -> all outputs at reset values immediately; after release, a new rate-3 frame encodes correctly.
REQ-031 Change i_code_rate and i_gen_poly mid-FEED -> o_code_rate and o_gen_poly unchanged until the next acceptance.
